// File: rtl/ysyx_22041071_id_stage.sv
// Decode/register-read stage: integer register file, operand forwarding, load-use stall and EX output register.
// Optional macro YSYX_22041071_FWD_EN enables forwarding from fwd_data; without it any forward match stalls.
module ysyx_22041071_id_stage #(
    parameter  int XLEN   = 64,
    parameter  int NREG   = 32,
    parameter  int NFWD   = 3,
    parameter  int CTRL_W = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [31:0]          ins_in,
    input  logic [RW-1:0]        rs1,
    input  logic [RW-1:0]        rs2,
    input  logic [RW-1:0]        rd,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic [XLEN-1:0]      imm,
    input  logic [1:0]           src1_sel,
    input  logic [1:0]           src2_sel,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic                 flush,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD*RW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 fwd0_is_load,
    input  logic                 wb_en,
    input  logic [RW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [XLEN-1:0]      pc_out,
    output logic [31:0]          ins_out,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [RW-1:0]        rd_out,
    output logic [XLEN-1:0]      src_a,
    output logic [XLEN-1:0]      src_b,
    output logic [XLEN-1:0]      rs2_data,
    output logic [XLEN-1:0]      jalr_target
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;
    logic [XLEN-1:0] jalr_sum;
    logic            stall;
    logic            accept;

    // Priority from lowest to highest: register file, write-back, oldest..youngest forward, x0.
    function automatic logic [XLEN-1:0] resolve(input logic [RW-1:0] rs);
        logic [XLEN-1:0] v;
        v = regs[rs];
        if (wb_en && wb_rd == rs)
            v = wb_data;
`ifdef YSYX_22041071_FWD_EN
        for (int i = NFWD - 1; i >= 0; i--)
            if (fwd_en[i] && fwd_rd[i*RW +: RW] == rs)
                v = fwd_data[i*XLEN +: XLEN];
`endif
        if (rs == '0)
            v = '0;
        return v;
    endfunction

    always_comb begin
        rs1_val = resolve(rs1);
        rs2_val = resolve(rs2);
    end

`ifdef YSYX_22041071_FWD_EN
    always_comb begin
        stall = valid_in && fwd_en[0] && fwd0_is_load &&
                ((use_rs1 && rs1 == fwd_rd[RW-1:0] && rs1 != '0) ||
                 (use_rs2 && rs2 == fwd_rd[RW-1:0] && rs2 != '0));
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_data, fwd0_is_load};

    // Without forwarding, every in-flight producer of a needed register blocks issue.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_en[i] &&
                ((use_rs1 && rs1 == fwd_rd[i*RW +: RW] && rs1 != '0) ||
                 (use_rs2 && rs2 == fwd_rd[i*RW +: RW] && rs2 != '0)))
                stall = valid_in;
    end
`endif

    assign ready_out   = (!valid_out || ready_in) && !stall;
    assign accept      = valid_in && ready_out && !flush;
    assign jalr_sum    = rs1_val + imm;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        a_next = '0;
        b_next = '0;
        case (src1_sel)
            2'd0:    a_next = rs1_val;
            2'd2:    a_next = pc_in;
            default: a_next = '0;
        endcase
        case (src2_sel)
            2'd0:    b_next = rs2_val;
            2'd1:    b_next = imm;
            2'd2:    b_next = XLEN'(4);
            default: b_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output register: flush > backpressure hold > bubble on stall > accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            pc_out    <= '0;
            ins_out   <= '0;
            ctrl_out  <= '0;
            rd_out    <= '0;
            src_a     <= '0;
            src_b     <= '0;
            rs2_data  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!valid_out || ready_in) begin
            valid_out <= accept;
            if (accept) begin
                pc_out   <= pc_in;
                ins_out  <= ins_in;
                ctrl_out <= ctrl_in;
                rd_out   <= rd;
                src_a    <= a_next;
                src_b    <= b_next;
                rs2_data <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_id_stage.sv
// Directed bench for ysyx_22041071_id_stage: vector table plus hand sequences for stall, backpressure, flush and reset.
module tb_ysyx_22041071_id_stage;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NFWD = 3;
    localparam int CTRL_W = 16;
    localparam int RW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_in;
    logic                 ready_out;
    logic [XLEN-1:0]      pc_in;
    logic [31:0]          ins_in;
    logic [RW-1:0]        rs1, rs2, rd;
    logic                 use_rs1, use_rs2;
    logic [XLEN-1:0]      imm;
    logic [1:0]           src1_sel, src2_sel;
    logic [CTRL_W-1:0]    ctrl_in;
    logic                 flush;
    logic [NFWD-1:0]      fwd_en;
    logic [NFWD*RW-1:0]   fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 fwd0_is_load;
    logic                 wb_en;
    logic [RW-1:0]        wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 valid_out;
    logic                 ready_in;
    logic [XLEN-1:0]      pc_out;
    logic [31:0]          ins_out;
    logic [CTRL_W-1:0]    ctrl_out;
    logic [RW-1:0]        rd_out;
    logic [XLEN-1:0]      src_a, src_b, rs2_data, jalr_target;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22041071_id_stage #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .pc_in(pc_in), .ins_in(ins_in), .rs1(rs1), .rs2(rs2), .rd(rd),
        .use_rs1(use_rs1), .use_rs2(use_rs2), .imm(imm),
        .src1_sel(src1_sel), .src2_sel(src2_sel), .ctrl_in(ctrl_in), .flush(flush),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd0_is_load(fwd0_is_load),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .valid_out(valid_out), .ready_in(ready_in),
        .pc_out(pc_out), .ins_out(ins_out), .ctrl_out(ctrl_out), .rd_out(rd_out),
        .src_a(src_a), .src_b(src_b), .rs2_data(rs2_data), .jalr_target(jalr_target)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [1:0]  s1, s2;
        logic [63:0] imm;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [63:0] wbd;
        logic [63:0] ea, eb, er, ej;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rs1 rs2 s1 s2 imm wbe wbrd wbd | src_a src_b rs2_data jalr
        tbl[0] = '{5'd5, 5'd0, 2'd0, 2'd1, 64'h100, 1'b1, 5'd5, 64'h11,
                   64'h11, 64'h100, 64'h0, 64'h110};
        tbl[1] = '{5'd5, 5'd5, 2'd0, 2'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                   64'h11, 64'h11, 64'h11, 64'h10};
        tbl[2] = '{5'd0, 5'd0, 2'd0, 2'd2, 64'h0, 1'b1, 5'd0, 64'hFF,
                   64'h0, 64'h4, 64'h0, 64'h0};
        tbl[3] = '{5'd3, 5'd5, 2'd0, 2'd0, 64'h11, 1'b1, 5'd3, 64'h1234,
                   64'h1234, 64'h11, 64'h11, 64'h1244};
        tbl[4] = '{5'd3, 5'd3, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 5'd0, 64'h0,
                   64'h1234, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234, 64'h122C};
        tbl[5] = '{5'd5, 5'd0, 2'd1, 2'd2, 64'h0, 1'b0, 5'd0, 64'h0,
                   64'h0, 64'h4, 64'h0, 64'h10};
        tbl[6] = '{5'd0, 5'd3, 2'd2, 2'd0, 64'h7, 1'b1, 5'd3, 64'h55,
                   64'h1018, 64'h55, 64'h55, 64'h6};

        reset = 1'b0; valid_in = 1'b0; pc_in = '0; ins_in = '0; rs1 = '0; rs2 = '0; rd = '0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; imm = '0; src1_sel = '0; src2_sel = '0; ctrl_in = '0;
        flush = 1'b0; fwd_en = '0; fwd_rd = '0; fwd_data = '0; fwd0_is_load = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ready_in = 1'b1;

        #2;
        chk("reset valid_out", 64'(valid_out), 64'h0);
        chk("reset src_a", src_a, 64'h0);
        chk("reset src_b", src_b, 64'h0);
        chk("reset rs2_data", rs2_data, 64'h0);
        chk("reset pc_out", pc_out, 64'h0);
        chk("reset ctrl_out", 64'(ctrl_out), 64'h0);
        #10 reset = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) begin
            valid_in = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            rs1 = tbl[k].rs1; rs2 = tbl[k].rs2; src1_sel = tbl[k].s1; src2_sel = tbl[k].s2;
            imm = tbl[k].imm; wb_en = tbl[k].wbe; wb_rd = tbl[k].wbrd; wb_data = tbl[k].wbd;
            pc_in = 64'h1000 + 64'(4 * k); ins_in = 32'hABC0_0000 | 32'(k);
            rd = 5'(k + 1); ctrl_in = 16'(3 * k);
            #1;
            chk($sformatf("v%0d jalr_target", k), jalr_target, tbl[k].ej);
            chk($sformatf("v%0d ready_out", k), 64'(ready_out), 64'h1);
            tick();
            chk($sformatf("v%0d valid_out", k), 64'(valid_out), 64'h1);
            chk($sformatf("v%0d src_a", k), src_a, tbl[k].ea);
            chk($sformatf("v%0d src_b", k), src_b, tbl[k].eb);
            chk($sformatf("v%0d rs2_data", k), rs2_data, tbl[k].er);
            chk($sformatf("v%0d pc_out", k), pc_out, 64'h1000 + 64'(4 * k));
            chk($sformatf("v%0d ins_out", k), 64'(ins_out), 64'(32'hABC0_0000 | 32'(k)));
            chk($sformatf("v%0d rd_out", k), 64'(rd_out), 64'(k + 1));
            chk($sformatf("v%0d ctrl_out", k), 64'(ctrl_out), 64'(3 * k));
        end
        wb_en = 1'b0;

        // Two older sources both target x5; x5 holds 0x11 in the register file.
        rs1 = 5'd5; rs2 = 5'd0; use_rs1 = 1'b1; use_rs2 = 1'b0; src1_sel = 2'd0; src2_sel = 2'd1; imm = '0;
        fwd_rd = {5'd5, 5'd5, 5'd0}; fwd_data = {64'h33, 64'h22, 64'h0}; fwd_en = 3'b110;
`ifdef YSYX_22041071_FWD_EN
        #1 chk("fwdprio ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("fwdprio valid_out", 64'(valid_out), 64'h1);
        chk("fwdprio src_a", src_a, 64'h22);
`else
        #1 chk("nofwd stall0 ready_out", 64'(ready_out), 64'h0);
        tick();
        chk("nofwd stall0 valid_out", 64'(valid_out), 64'h0);
        fwd_en = 3'b100;
        #1 chk("nofwd stall1 ready_out", 64'(ready_out), 64'h0);
        tick();
        chk("nofwd stall1 valid_out", 64'(valid_out), 64'h0);
        fwd_en = 3'b000;
        #1 chk("nofwd clear ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("nofwd clear valid_out", 64'(valid_out), 64'h1);
        chk("nofwd clear src_a", src_a, 64'h11);
`endif

        // x0 read with write to x0 and a load targeting x0
        rs1 = 5'd0; rs2 = 5'd7; use_rs1 = 1'b1; use_rs2 = 1'b0; src1_sel = 2'd0;
        fwd_en = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd0}; fwd_data = {64'h0, 64'h0, 64'hEE};
        fwd0_is_load = 1'b1; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        #1 chk("x0 ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("x0 src_a", src_a, 64'h0);
        wb_en = 1'b0;
        fwd_rd = {5'd0, 5'd0, 5'd7};
        #1 chk("unused rs2 ready_out", 64'(ready_out), 64'h1);

        // Load-use on rs2
        rs1 = 5'd0; rs2 = 5'd7; use_rs2 = 1'b1; src2_sel = 2'd0;
        #1 chk("loaduse ready_out", 64'(ready_out), 64'h0);
        tick();
        chk("loaduse bubble valid_out", 64'(valid_out), 64'h0);
`ifdef YSYX_22041071_FWD_EN
        fwd_en = 3'b010; fwd_rd = {5'd0, 5'd7, 5'd0}; fwd_data = {64'h0, 64'hAB, 64'h0}; fwd0_is_load = 1'b0;
        #1 chk("loaduse next ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("loaduse next valid_out", 64'(valid_out), 64'h1);
        chk("loaduse src_b", src_b, 64'hAB);
        chk("loaduse rs2_data", rs2_data, 64'hAB);
`endif
        valid_in = 1'b0; fwd_en = '0; fwd0_is_load = 1'b0; fwd_data = '0;
        tick();

        // Backpressure: hold bundle A for three cycles while B waits
        valid_in = 1'b1; rs1 = 5'd3; use_rs1 = 1'b1; use_rs2 = 1'b0; src1_sel = 2'd0;
        pc_in = 64'h2000; ready_in = 1'b0;
        #1 chk("bp first ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("bp A valid_out", 64'(valid_out), 64'h1);
        chk("bp A src_a", src_a, 64'h55);
        rs1 = 5'd5; pc_in = 64'h2004;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("bp%0d ready_out", c), 64'(ready_out), 64'h0);
            tick();
            chk($sformatf("bp%0d valid_out", c), 64'(valid_out), 64'h1);
            chk($sformatf("bp%0d src_a", c), src_a, 64'h55);
            chk($sformatf("bp%0d pc_out", c), pc_out, 64'h2000);
        end
        ready_in = 1'b1;
        #1 chk("bp release ready_out", 64'(ready_out), 64'h1);
        tick();
        chk("bp B src_a", src_a, 64'h11);
        chk("bp B pc_out", pc_out, 64'h2004);

        // Flush kills the incoming instruction but not the write-back
        flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        tick();
        chk("flush valid_out", 64'(valid_out), 64'h0);
        flush = 1'b0; wb_en = 1'b0; rs1 = 5'd9; rs2 = 5'd5; src2_sel = 2'd0; pc_in = 64'h3000;
        tick();
        chk("after flush valid_out", 64'(valid_out), 64'h1);
        chk("after flush src_a", src_a, 64'h99);

        // Asynchronous reset mid-stream clears outputs and the register file
        #2 reset = 1'b0;
        #1;
        chk("midreset valid_out", 64'(valid_out), 64'h0);
        chk("midreset src_a", src_a, 64'h0);
        chk("midreset pc_out", pc_out, 64'h0);
        #3 reset = 1'b1;
        tick();
        chk("postreset valid_out", 64'(valid_out), 64'h1);
        chk("postreset src_a", src_a, 64'h0);
        chk("postreset src_b", src_b, 64'h0);
        chk("postreset pc_out", pc_out, 64'h3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_id_stage.md
# ysyx_22041071_id_stage

Parametrised decode/register-read stage for the ysyx_22041071 in-order pipeline. It owns the integer register file and resolves operands from it, the write-back port, or N in-flight forwarding sources. It detects load-use hazards and presents a registered operand bundle to EX over a valid/ready handshake. Register width, register count, forwarding depth and control-bundle width are parameters.

## Interface
- XLEN, 64, data/register width
- NREG, 32, architectural registers; power of two, 2..32; RW = $clog2(NREG)
- NFWD, 3, forwarding sources; index 0 = EX (youngest), NFWD-1 = oldest
- CTRL_W, 16, opaque control bundle passed to EX unchanged
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- valid_in  in  1  upstream instruction valid
- ready_out  out  1  stage accepts an instruction this cycle
- pc_in / ins_in  in  XLEN / 32  PC and raw instruction
- rs1, rs2, rd  in  RW each  register indices
- use_rs1, use_rs2  in  1 each  instruction actually reads rs1/rs2
- imm  in  XLEN  immediate, already sign-extended
- src1_sel  in  2  0 = rs1 value, 1 = zero, 2 = pc_in
- src2_sel  in  2  0 = rs2 value, 1 = imm, 2 = constant 4
- ctrl_in  in  CTRL_W  control bundle
- flush  in  1  kill the instruction in this stage and in the output register
- fwd_en  in  NFWD  source i writes a register
- fwd_rd  in  NFWD*RW  destination of source i, packed with i=0 in the LSBs
- fwd_data  in  NFWD*XLEN  result of source i, packed
- fwd0_is_load  in  1  source 0 is a load; data not yet available
- wb_en, wb_rd, wb_data  in  1 / RW / XLEN  register-file write port
- valid_out  out  1  output bundle valid
- ready_in  in  1  EX accepts the bundle
- pc_out, ins_out, ctrl_out, rd_out  out  XLEN / 32 / CTRL_W / RW  registered copies
- src_a, src_b, rs2_data  out  XLEN each  registered operands; rs2_data is the store data
- jalr_target  out  XLEN  combinational: resolved rs1 value + imm, bit 0 cleared

## Operation
- Register file: NREG x XLEN.
  - Written on a clk edge when wb_en && wb_rd != 0.
  - x0 reads zero always.
- Operand resolution, per source (rs1, rs2), is combinational. The first match in this list wins:
  - rs == 0 → zero.
  - Lowest i with fwd_en[i] && fwd_rd[i] == rs → fwd_data[i].
  - wb_en && wb_rd == rs → wb_data (write-through).
  - Otherwise the register-file entry.
- Load-use stall is asserted when all of the following hold:
  - valid_in
  - fwd_en[0] && fwd0_is_load
  - (use_rs1 && rs1 == fwd_rd[0] && rs1 != 0) || (use_rs2 && rs2 == fwd_rd[0] && rs2 != 0)
- ready_out = (!valid_out || ready_in) && !stall.
- Accept = valid_in && ready_out && !flush. On accept the output register loads:
  - src_a, src_b per the selects;
  - rs2_data = resolved rs2;
  - pc, ins, ctrl and rd passed through.
- Stall with downstream free (!valid_out || ready_in): the output register loads a bubble. valid_out = 0 and the payload is held.
- Backpressure (valid_out && !ready_in): every output register holds.
- flush:
  - valid_out clears at the next edge.
  - The incoming instruction is not accepted.
  - The register-file write still happens.

## Timing
- Latency is one cycle from accept to valid_out.
- Throughput is one instruction per cycle absent stalls.
- Load-use costs exactly one bubble. The next cycle the load appears at index 1 and forwards normally.
- A write-back and a read of the same register in the same cycle return the new data.
- Reset values:
  - valid_out 0.
  - pc_out, ins_out, ctrl_out, rd_out, src_a, src_b, rs2_data all 0.
  - All registers 0.
- Reset takes effect immediately, mid-operation included. The first accept is possible on the first edge after release.
- flush has priority over accept and over stall. The same edge that sees flush never raises valid_out.
- jalr_target uses the same resolution path as rs1, so it is valid in the same cycle.

## Configuration
- YSYX_22041071_FWD_EN
  - Defined: forwarding from fwd_data as described.
  - Undefined: fwd_data is ignored. Any use_rs match against an enabled fwd_rd (nonzero rs) raises the stall, and stays up until that source clears. The wb write-through remains in both builds.

## Test plan
- Forward priority: write x5=0x11 via wb. Set fwd_en=3'b110 with fwd_rd[1]=fwd_rd[2]=5, data 0x22 (source 1) and 0x33 (source 2). Issue add with rs1=5 → src_a=0x22.
- Load-use: fwd_en[0]=1, fwd0_is_load=1, fwd_rd[0]=7; issue rs2=7, use_rs2=1 → ready_out=0 for one cycle, one bubble (valid_out=0). Next cycle, with the load at index 1 carrying 0xAB → src_b=0xAB.
- Backpressure: valid_out=1, ready_in=0 for 3 cycles while valid_in=1 → outputs stable, ready_out=0. Release → new bundle the next edge.
- x0: wb_en=1, wb_rd=0, wb_data=0xFF; fwd_rd[0]=0 → a read of rs1=0 gives src_a=0.
- Write-through: wb x3=0x1234 in the same cycle as issuing rs1=3 → src_a=0x1234. The register file holds 0x1234 afterwards.
- Flush and reset: assert flush with valid_in=1 → valid_out=0 next cycle. Drop reset mid-stream → valid_out=0 and src_a=0 immediately. In a build without YSYX_22041071_FWD_EN, an rs1 match on fwd_en[2] stalls until that source clears.
